// File: rtl/plic_pkg.sv
// Shared PLIC types and helpers: claim-controller FSM states and the
// source-ID to one-hot decode also used by the gateway block.
package plic_pkg;

  localparam int MAX_SOURCES = 32;

  typedef enum logic {
    SCAN    = 1'b0,
    PUBLISH = 1'b1
  } plic_state_t;

  // ID 0 and IDs beyond MAX_SOURCES decode to all-zero.
  function automatic logic [MAX_SOURCES-1:0] id_to_onehot(input logic [7:0] id);
    logic [MAX_SOURCES-1:0] oh;
    oh = '0;
    for (int n = 1; n <= MAX_SOURCES; n++) begin
      if (id == 8'(n)) oh[n-1] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/plic_scan_cmp.sv
// Candidate qualify/compare for the source currently addressed by the scan
// index: pending, enabled and strictly above the best priority seen so far.
module plic_scan_cmp #(
  parameter int SOURCES       = 8,
  parameter int SOURCES_BITS  = 4,
  parameter int PRIORITY_BITS = 3
) (
  input  logic [SOURCES-1:0]               ip_i,
  input  logic [SOURCES-1:0]               ie_i,
  input  logic [SOURCES*PRIORITY_BITS-1:0] priority_i,
  input  logic [SOURCES_BITS-1:0]          idx,
  input  logic [PRIORITY_BITS-1:0]         best_pri,
  output logic                             cand,
  output logic [PRIORITY_BITS-1:0]         cand_pri
);

  logic pend;

  always_comb begin
    pend     = 1'b0;
    cand_pri = '0;
    for (int n = 0; n < SOURCES; n++) begin
      if (idx == SOURCES_BITS'(n + 1)) begin
        pend     = ip_i[n] & ie_i[n];
        cand_pri = priority_i[n*PRIORITY_BITS +: PRIORITY_BITS];
      end
    end
  end

  // Strict compare: ties keep the lower ID, priority 0 never beats best_pri=0.
  assign cand = pend && (cand_pri > best_pri);

endmodule

// File: rtl/plic_claim_ctrl.sv
// Per-target PLIC claim/complete controller: scans one source per clock,
// publishes the winner as EIP/ID, and answers claim/complete accesses.
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int SOURCES       = 8,
  parameter int PRIORITIES    = 7,
  parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
  input  logic                             rst_n,
  input  logic                             clk,
  input  logic [SOURCES-1:0]               ip_i,
  input  logic [SOURCES-1:0]               ie_i,
  input  logic [SOURCES*PRIORITY_BITS-1:0] priority_i,
  input  logic [PRIORITY_BITS-1:0]         threshold_i,
  input  logic                             claim_i,
  input  logic                             complete_i,
  input  logic [SOURCES_BITS-1:0]          complete_id_i,
  output logic                             ireq_o,
  output logic [SOURCES_BITS-1:0]          id_o,
  output logic [SOURCES-1:0]               claim_o,
  output logic [SOURCES-1:0]               complete_o,
  output logic                             state_o,
  output logic [PRIORITY_BITS-1:0]         cur_pri_o
);

  // claim_i/complete_i are single-cycle strobes with no back-pressure: each
  // sampled strobe is always accepted and answered on the following cycle.

  plic_state_t              state, state_d;
  logic [SOURCES_BITS-1:0]  idx, idx_d;
  logic [SOURCES_BITS-1:0]  best_id, best_id_d, cur_id, cur_id_d, id_d;
  logic [PRIORITY_BITS-1:0] best_pri, best_pri_d, cur_pri, cur_pri_d;
  logic                     ireq_d;
  logic [SOURCES-1:0]       claim_d, complete_d, claim_dec, cmp_dec;
  logic                     cand;
  logic [PRIORITY_BITS-1:0] cand_pri;

  plic_scan_cmp #(
    .SOURCES      (SOURCES),
    .SOURCES_BITS (SOURCES_BITS),
    .PRIORITY_BITS(PRIORITY_BITS)
  ) u_scan_cmp (
    .ip_i      (ip_i),
    .ie_i      (ie_i),
    .priority_i(priority_i),
    .idx       (idx),
    .best_pri  (best_pri),
    .cand      (cand),
    .cand_pri  (cand_pri)
  );

  assign claim_dec = SOURCES'(id_to_onehot(8'(cur_id)));
  assign cmp_dec   = SOURCES'(id_to_onehot(8'(complete_id_i)));

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    best_id_d  = best_id;
    best_pri_d = best_pri;
    cur_id_d   = cur_id;
    cur_pri_d  = cur_pri;
    ireq_d     = ireq_o;
    id_d       = id_o;
    claim_d    = '0;
    complete_d = '0;

    case (state)
      SCAN: begin
        if (cand) begin
          best_id_d  = idx;
          best_pri_d = cand_pri;
        end
        if (idx == SOURCES_BITS'(SOURCES)) state_d = PUBLISH;
        else                               idx_d   = idx + SOURCES_BITS'(1);
      end
      PUBLISH: begin
        cur_id_d   = best_id;
        cur_pri_d  = best_pri;
        ireq_d     = (best_pri > threshold_i);
        best_id_d  = '0;
        best_pri_d = '0;
        idx_d      = SOURCES_BITS'(1);
        state_d    = SCAN;
      end
      default: state_d = SCAN;
    endcase

    // A claim overrides a coincident publish and restarts the sweep.
    if (claim_i) begin
      id_d       = cur_id;
      claim_d    = claim_dec;
      cur_id_d   = '0;
      cur_pri_d  = '0;
      ireq_d     = 1'b0;
      best_id_d  = '0;
      best_pri_d = '0;
      idx_d      = SOURCES_BITS'(1);
      state_d    = SCAN;
    end

    // Out-of-range IDs decode to zero, so only enabled valid IDs re-arm.
    if (complete_i) complete_d = cmp_dec & ie_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      idx        <= SOURCES_BITS'(1);
      best_id    <= '0;
      best_pri   <= '0;
      cur_id     <= '0;
      cur_pri    <= '0;
      ireq_o     <= 1'b0;
      id_o       <= '0;
      claim_o    <= '0;
      complete_o <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      best_id    <= best_id_d;
      best_pri   <= best_pri_d;
      cur_id     <= cur_id_d;
      cur_pri    <= cur_pri_d;
      ireq_o     <= ireq_d;
      id_o       <= id_d;
      claim_o    <= claim_d;
      complete_o <= complete_d;
    end
  end

  assign state_o   = (state == PUBLISH);
  assign cur_pri_o = cur_pri;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Bench for plic_claim_ctrl: directed and random claim/complete traffic
// checked by a queue-based scoreboard against an arbitration model.
module tb_plic_claim_ctrl;

  localparam int S  = 8;
  localparam int SB = 4;
  localparam int PB = 3;
  localparam int W  = SB + S;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [S-1:0]  ip_i = '0, ie_i = '0;
  logic [S*PB-1:0] priority_i = '0;
  logic [PB-1:0] threshold_i = '0;
  logic          claim_i = 1'b0, complete_i = 1'b0;
  logic [SB-1:0] complete_id_i = '0;
  logic          ireq_o, state_o;
  logic [SB-1:0] id_o;
  logic [S-1:0]  claim_o, complete_o;
  logic [PB-1:0] cur_pri_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [S-1:0] cmp_q[$];
  int prio[S];
  int exp_cur = 0;

  plic_claim_ctrl dut (
    .rst_n(rst_n), .clk(clk), .ip_i(ip_i), .ie_i(ie_i), .priority_i(priority_i),
    .threshold_i(threshold_i), .claim_i(claim_i), .complete_i(complete_i),
    .complete_id_i(complete_id_i), .ireq_o(ireq_o), .id_o(id_o), .claim_o(claim_o),
    .complete_o(complete_o), .state_o(state_o), .cur_pri_o(cur_pri_o)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model
  function automatic logic [S-1:0] onehot(input int id);
    logic [S-1:0] o;
    o = '0;
    if (id >= 1 && id <= S) o[id-1] = 1'b1;
    return o;
  endfunction

  function automatic int max_pri();
    int m = 0;
    for (int n = 0; n < S; n++)
      if (ip_i[n] && ie_i[n] && prio[n] > m) m = prio[n];
    return m;
  endfunction

  // Lowest ID among eligible sources holding the maximum priority.
  function automatic int winner();
    int m = max_pri();
    if (m == 0) return 0;
    for (int n = 0; n < S; n++)
      if (ip_i[n] && ie_i[n] && prio[n] == m) return n + 1;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks
  task automatic apply(input logic [S-1:0] ip, input logic [S-1:0] ie, input int thr);
    ip_i = ip;
    ie_i = ie;
    threshold_i = PB'(thr);
    for (int n = 0; n < S; n++) priority_i[n*PB +: PB] = PB'(prio[n]);
  endtask

  task automatic settle();
    repeat (2*S + 4) @(posedge clk);
    #1;
    exp_cur = winner();
  endtask

  task automatic op(input bit clm, input bit cmp, input int cid);
    if (clm) begin
      exp_q.push_back({SB'(exp_cur), onehot(exp_cur)});
      exp_cur = 0;
    end
    if (cmp) cmp_q.push_back((cid >= 1 && cid <= S && ie_i[cid-1]) ? onehot(cid) : '0);
    claim_i = clm;
    complete_i = cmp;
    complete_id_i = SB'(cid);
    @(posedge clk);
    #1;
    claim_i = 1'b0;
    complete_i = 1'b0;
  endtask

  // ---------------- scoreboard monitor
  initial begin
    logic [W-1:0] e;
    logic [S-1:0] ce;
    bit c, k;
    forever begin
      @(posedge clk);
      c = claim_i;
      k = complete_i;
      @(negedge clk);
      if (c) begin
        if (exp_q.size() == 0) check("claim_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("claim_id", int'(id_o), int'(e[W-1:S]));
          check("claim_pulse", int'(claim_o), int'(e[S-1:0]));
        end
      end else if (claim_o != '0) check("claim_spurious", int'(claim_o), 0);
      if (k) begin
        if (cmp_q.size() == 0) check("complete_unexpected", 1, 0);
        else begin
          ce = cmp_q.pop_front();
          check("complete_pulse", int'(complete_o), int'(ce));
        end
      end else if (complete_o != '0) check("complete_spurious", int'(complete_o), 0);
    end
  end

  // ---------------- stimulus
  initial begin
    int n;
    #1;
    check("rst_ireq", ireq_o, 0);
    check("rst_id", id_o, 0);
    check("rst_claim", claim_o, 0);
    check("rst_complete", complete_o, 0);
    check("rst_cur_pri", cur_pri_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Source 3 @2, source 5 @6, threshold 1.
    foreach (prio[i]) prio[i] = 0;
    prio[2] = 2; prio[4] = 6;
    apply(8'b0001_0100, 8'hFF, 1);
    settle();
    check("dir_ireq_thr1", ireq_o, 1);
    check("dir_cur_pri", cur_pri_o, 6);
    op(1, 0, 0);
    check("dir_ireq_after_claim", ireq_o, 0);

    // Threshold equal to best priority: no EIP, claim still answers.
    apply(8'b0001_0100, 8'hFF, 6);
    settle();
    check("dir_ireq_thr6", ireq_o, 0);
    op(1, 0, 0);

    // Tie at priority 4 between sources 2 and 7.
    foreach (prio[i]) prio[i] = 0;
    prio[1] = 4; prio[6] = 4;
    apply(8'b0100_0010, 8'hFF, 0);
    settle();
    check("dir_tie_ireq", ireq_o, 1);
    op(1, 0, 0);

    // Back-to-back claims, then EIP must stay low for a full sweep.
    settle();
    op(1, 0, 0);
    op(1, 0, 0);
    for (int i = 0; i < S + 1; i++) begin
      check("ireq_low_after_claim", ireq_o, 0);
      @(posedge clk); #1;
    end

    // Complete: valid, ID 0, ID 9, disabled source, and with a claim.
    prio[4] = 5;
    apply(8'b0001_0000, 8'hFF, 0);
    op(0, 1, 5);
    op(0, 1, 0);
    op(0, 1, 9);
    ie_i = 8'hEF;
    op(0, 1, 5);
    ie_i = 8'hFF;
    settle();
    op(1, 1, 5);

    // Reset mid-sweep.
    settle();
    check("pre_reset_ireq", ireq_o, 1);
    repeat ($urandom_range(0, S)) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_cur = 0;
    #1;
    check("mid_rst_ireq", ireq_o, 0);
    check("mid_rst_id", id_o, 0);
    check("mid_rst_cur_pri", cur_pri_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ireq_o && n < 4*S);
    check("rst_release_publish_cycles", n, S + 1);

    // Reset asserted together with a claim: nothing is returned.
    settle();
    exp_q.push_back('0);
    claim_i = 1'b1;
    rst_n = 1'b0;
    exp_cur = 0;
    #1;
    check("claim_rst_ireq", ireq_o, 0);
    check("claim_rst_claim", claim_o, 0);
    @(posedge clk); #1;
    claim_i = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      foreach (prio[i]) prio[i] = $urandom_range(0, 6);
      apply(S'($urandom_range(0, 255)), S'($urandom_range(0, 255)), $urandom_range(0, 6));
      settle();
      check("rnd_ireq", ireq_o, (max_pri() > int'(threshold_i)) ? 1 : 0);
      check("rnd_cur_pri", cur_pri_o, max_pri());
      repeat ($urandom_range(0, S)) @(posedge clk);
      #0;
      op(1, 1'($urandom_range(0, 1)), $urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) op(1, 0, 0);
      op(0, 1, $urandom_range(0, 9));
    end

    repeat (3) @(posedge clk);
    #1;
    check("claim_q_drained", exp_q.size(), 0);
    check("complete_q_drained", cmp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    check("timeout", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plic_claim_ctrl.md
# plic_claim_ctrl

Per-target claim/complete controller for the PLIC. Sequentially scans all interrupt sources, one per clock, to find the highest-priority pending and enabled source. Publishes the winner's ID and interrupt request to its target, and services the target's claim and complete accesses by pulsing one-hot clear/complete strobes back to the source gateways. One instance sits between the gateway/register block and each target's EIP line.

## Interface
- SOURCES, 8, number of interrupt sources; IDs 1..SOURCES, ID 0 reserved for "none"
- PRIORITIES, 7, number of priority levels; priority 0 means never interrupt
- SOURCES_BITS, $clog2(SOURCES+1), ID width
- PRIORITY_BITS, $clog2(PRIORITIES), priority/threshold width

- rst_n  in  1  reset, asynchronous, active-low
- clk  in  1  clock
- ip_i  in  SOURCES  pending bits from gateways; bit n-1 = source n
- ie_i  in  SOURCES  enable bits for this target
- priority_i  in  SOURCES*PRIORITY_BITS  packed priorities; slice n-1 = source n
- threshold_i  in  PRIORITY_BITS  target threshold
- claim_i  in  1  single-cycle claim-read strobe
- complete_i  in  1  single-cycle complete-write strobe
- complete_id_i  in  SOURCES_BITS  ID being completed
- ireq_o  out  1  interrupt request (EIP) to target
- id_o  out  SOURCES_BITS  claim response ID
- claim_o  out  SOURCES  one-hot pulse, clears pending in gateway n-1
- complete_o  out  SOURCES  one-hot pulse, re-arms gateway n-1

## Operation
- FSM states are SCAN and PUBLISH. Reset state is SCAN with idx=1.
- SCAN behaviour, each cycle:
  - Source idx is a candidate if ip&ie and its priority > best_pri.
  - If it is a candidate: best_id<=idx and best_pri<=prio. Strict compare means ties go to the lowest ID, and priority 0 never wins (best_pri starts at 0).
  - If idx==SOURCES: go to PUBLISH; otherwise idx++.
- PUBLISH behaviour (one cycle):
  - cur_id<=best_id and cur_pri<=best_pri.
  - ireq_o<=(best_pri>threshold_i).
  - Clear best_id and best_pri to 0, idx<=1, go to SCAN.
- Claim, accepted in any state:
  - id_o<=cur_id.
  - If cur_id!=0, claim_o[cur_id-1] pulses for one cycle.
  - cur_id, cur_pri and ireq_o are cleared.
  - The current sweep is aborted: best cleared, idx<=1, state SCAN.
  - A claim is never refused; it returns 0 when nothing is pending.
- Complete:
  - If 1<=complete_id_i<=SOURCES and ie_i[complete_id_i-1]=1, complete_o[complete_id_i-1] pulses next cycle.
  - Otherwise the complete is silently ignored.
- Simultaneous claim and complete: both are serviced independently in the same cycle. A claim in the same cycle as PUBLISH takes precedence: it returns the pre-PUBLISH cur_id and the publish is discarded.
- Threshold and enable changes affect ireq_o only at the next PUBLISH.

## Timing
- Reset values: ireq_o=0, id_o=0, claim_o=0, complete_o=0, cur_id=0, cur_pri=0, state SCAN, idx=1.
- Sweep period is SOURCES+1 cycles.
- Worst-case latency from ip_i rising to ireq_o rising is 2*SOURCES+1 cycles.
- id_o and claim_o update on the clock edge after the claim_i sample. id_o holds until the next claim.
- complete_o is asserted for the one cycle after the complete_i sample.
- After a claim, ireq_o stays low for at least SOURCES+1 cycles (one full sweep).
- A back-to-back second claim returns 0.
- Reset asserted mid-sweep clears everything asynchronously; the first PUBLISH after release is at cycle SOURCES+1.

## Structure
- plic_pkg holds:
  - state enum {SCAN, PUBLISH}
  - helper function for the ID-to-one-hot decode, shared with the gateway block
- Sub-module plic_scan_cmp is the natural split. It holds the combinational candidate qualify/compare for one index and returns the candidate flag and priority. The FSM, counter and output registers stay in the top module.

## Test plan
- SOURCES=8. Source 3 at prio 2 and source 5 at prio 6, both pending and enabled, threshold 1.
  - Required: after the sweep, ireq_o=1. A claim gives id_o=5 and a claim_o=8'b0001_0000 pulse.
- Tie: sources 2 and 7 both at prio 4.
  - Required: a claim returns 2.
- Threshold 6 with best prio 6.
  - Required: ireq_o=0, but a claim still returns 5 and pulses claim_o.
- Two claims 1 cycle apart.
  - Required: second returns 0 with no claim_o pulse; ireq_o stays low ≥9 cycles.
- Complete sequence:
  - complete_id_i=5 with enable set gives complete_o[4] pulse.
  - complete_id_i=0, complete_id_i=9, or source 5 disabled gives no pulse.
  - Claim and complete in the same cycle: both outputs pulse.
- Assert rst_n low mid-sweep and on a claim cycle.
  - Required: all outputs are 0 immediately, and ireq_o rises ≥9 cycles after release.
